decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
// - Registered, handshaked RV32I decode stage; successor to the combinational decoder.
// - Sits between fetch and execute.
// - Decodes one instruction per accepted transfer into fields, immediate, valid flags and a one-hot op bus.
// - Buffers results in a BUF_DEPTH-entry output FIFO with valid/ready on both sides.
// - Flags illegal encodings and supports a flush.
// PARAMETERS
// - PC_W       32  width of the pc carried alongside each instruction
// - BUF_DEPTH  2   output FIFO entries; legal range 1..4
// - BUS_W      localparam, not overridable: 38 by default, 46 with RV32M_EN
// PORTS
// - clk        in   1      single clock; all state updates on posedge
// - rst        in   1      synchronous, active-high reset
// - flush      in   1      synchronous: discards all buffered entries
// - in_valid   in   1      fetch offers instr/pc
// - in_ready   out  1      stage accepts this cycle
// - instr      in   32     instruction word
// - pc         in   PC_W   instruction address
// - out_valid  out  1      head entry valid
// - out_ready  in   1      execute consumes head
// - out_pc     out  PC_W   pc of head entry
// - rs1, rs2, rd            out  5 each  register fields: instr[19:15], [24:20], [11:7]
// - func3, func7            out  3/7     instr[14:12], instr[31:25]
// - imm                     out  32      sign-extended immediate
// - rs1_valid, rs2_valid, rd_valid, func3_valid, func7_valid, imm_valid   out  1 each
// - instr_bus  out  BUS_W  one-hot op
// - illegal    out  1      equals instr_bus[37]
// BEHAVIOUR
// - Reset (rst=1 at posedge): FIFO count=0, rd/wr pointers=0, out_valid=0. All payload outputs read 0. in_ready=0 while rst=1.
// - Accept: in_valid && in_ready. in_ready = !rst && (count < BUF_DEPTH). No combinational path from out_ready to in_ready.
// - Pop: out_valid && out_ready. out_valid = (count != 0). Payload is driven from the head entry and stays stable while out_valid && !out_ready.
// - Latency: decode is combinational on instr; an entry is written at the accept edge. With the FIFO empty, outputs are valid the next cycle.
// - Push and pop in the same cycle: count is unchanged; both pointers advance modulo BUF_DEPTH.
// - Flush: count=0 and pointers=0 at the edge. A push or pop in that cycle is discarded. rst has priority over flush.
// - Types by opcode:
//   - R 0110011
//   - I 0010011, 0000011, 1100111
//   - S 0100011
//   - B 1100011
//   - J 1101111
//   - U 0110111, 0010111
// - Immediates:
//   - I: {{20{i[31]}},i[31:20]}
//   - S: {{20{i[31]}},i[31:25],i[11:7]}
//   - B: {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}
//   - U: {i[31:12],12'b0}
//   - J: {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}
//   - R: imm=0
// - Valids:
//   - rs1 / func3: R, I, S, B
//   - rs2: R, S, B
//   - rd: R, I, U, J
//   - func7: R
//   - imm: I, S, B, U, J
// - instr_bus bits 0..36 (existing map):
//   - 0-9 add sub xor or and sll srl sra slt sltu
//   - 10-18 addi xori ori andi slli srli srai slti sltiu
//   - 19-23 lb lh lw lbu lhu
//   - 24-26 sb sh sw
//   - 27-32 beq bne blt bge bltu bgeu
//   - 33 jal; 34 jalr; 35 lui; 36 auipc
// - Shift immediates: slli/srli need func7==7'h00; srai needs func7==7'h20.
// - Illegal: instr[1:0]!=2'b11, unknown opcode, or an opcode/func3/func7 combination outside the map.
//   - bit 37 is set; all other bus bits and all *_valid are 0.
//   - The entry is still buffered and delivered normally.
// - Exactly one instr_bus bit is set per valid entry.
// CONFIGURATION
// - RV32M_EN defined: BUS_W=46. R-type with func7==7'h01 decodes by func3 0..7 into bits 38..45:
//   - mul mulh mulhsu mulhu div divu rem remu
// - RV32M_EN undefined: BUS_W=38. Every func7==7'h01 R-type is illegal (bit 37).
// TESTING
// - T1 rst 2 cycles, then idle -> out_valid=0, in_ready=1, count=0. Payload outputs 0 while out_valid=0 after reset.
// - T2 push 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, bus[10]=1, rs2_valid=0.
// - T3 BUF_DEPTH=2, out_ready=0, push 0x402081B3 (sub) then 0xFFDFF0EF (jal x1,-4) -> in_ready=0 after 2 accepts.
//   Head holds bus[1] stable; releasing out_ready yields jal with imm=0xFFFFFFFC, bus[33]=1.
// - T4 push 0x027302B3 (mul x5,x6,x7) -> with RV32M_EN bus[38]=1, rd=5; without, bus[37]=1, illegal=1, all valids 0.
// - T5 two entries buffered, assert flush with in_valid=1 -> next cycle out_valid=0, count=0; the offered word is not stored.
// - T6 continuous in_valid/out_ready, 100 random legal words -> one output per cycle, order preserved, exactly one bus bit set each.

Source files
------------

// File: rtl/decode_if.sv
// decode_if: fetch-side and execute-side handshake bundle for decode_stage.
// Macro RV32M_EN widens instr_bus from 38 to 46 bits to carry the M-extension ops.
interface decode_if #(
    parameter int PC_W = 32
);
`ifdef RV32M_EN
    localparam int BUS_W = 46;
`else
    localparam int BUS_W = 38;
`endif
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [PC_W-1:0]  pc;
    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic [31:0]      imm;
    logic             rs1_valid;
    logic             rs2_valid;
    logic             rd_valid;
    logic             func3_valid;
    logic             func7_valid;
    logic             imm_valid;
    logic [BUS_W-1:0] instr_bus;
    logic             illegal;

    modport master (
        output flush, in_valid, instr, pc, out_ready,
        input  in_ready, out_valid, out_pc, rs1, rs2, rd, func3, func7, imm,
               rs1_valid, rs2_valid, rd_valid, func3_valid, func7_valid, imm_valid,
               instr_bus, illegal
    );

    modport slave (
        input  flush, in_valid, instr, pc, out_ready,
        output in_ready, out_valid, out_pc, rs1, rs2, rd, func3, func7, imm,
               rs1_valid, rs2_valid, rd_valid, func3_valid, func7_valid, imm_valid,
               instr_bus, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decoder with a BUF_DEPTH-entry valid/ready output FIFO.
// Macro RV32M_EN: decodes R-type func7==0x01 into mul..remu on instr_bus[45:38].
module decode_stage #(
    parameter int PC_W      = 32,
    parameter int BUF_DEPTH = 2
) (
    input logic     clk,
    input logic     rst,
    decode_if.slave dif
);
`ifdef RV32M_EN
    localparam int BUS_W = 46;
`else
    localparam int BUS_W = 38;
`endif
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                           OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [5:0] ILL = 6'd37;

    logic [PC_W+31:0] mem_q [0:3];
    logic [2:0]       cnt_q, cnt_d;
    logic [1:0]       wp_q, wp_d, rp_q, rp_d;
    logic             push, pop, v;
    logic [31:0]      x;
    logic [PC_W-1:0]  hpc;
    logic [6:0]       opc, f7;
    logic [2:0]       f3;
    logic [5:0]       idx;
    logic             ok, tr, ti, ts, tb, tj, tu;
    logic [BUS_W-1:0] bus;

    assign v             = cnt_q != 3'd0;
    assign dif.in_ready  = !rst && (cnt_q < 3'(BUF_DEPTH));
    assign dif.out_valid = v;
    assign push          = dif.in_valid && dif.in_ready;
    assign pop           = v && dif.out_ready;

    // Occupancy and pointer next-state; push and pop together leave the count unchanged
    always_comb begin
        cnt_d = cnt_q + {2'd0, push} - {2'd0, pop};
        wp_d  = push ? (wp_q == 2'(BUF_DEPTH - 1) ? 2'd0 : wp_q + 2'd1) : wp_q;
        rp_d  = pop ? (rp_q == 2'(BUF_DEPTH - 1) ? 2'd0 : rp_q + 2'd1) : rp_q;
    end

    // FIFO state; flush discards this cycle's push/pop as well, rst takes priority
    always_ff @(posedge clk) begin
        if (rst || dif.flush) begin
            cnt_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
        end
    end

    // Entries keep the raw word and pc; the head is decoded combinationally
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {dif.pc, dif.instr};
    end

    // An empty FIFO presents an all-zero word so every payload output reads 0
    assign {hpc, x} = v ? mem_q[rp_q] : '0;
    assign opc      = x[6:0];
    assign f3       = x[14:12];
    assign f7       = x[31:25];

    // Map opcode/func3/func7 onto one instr_bus index; anything unmapped selects the illegal bit
    always_comb begin
        idx = ILL;
        case (opc)
            OP_R: case ({f7, f3})
                {7'h00, 3'd0}: idx = 6'd0;
                {7'h20, 3'd0}: idx = 6'd1;
                {7'h00, 3'd4}: idx = 6'd2;
                {7'h00, 3'd6}: idx = 6'd3;
                {7'h00, 3'd7}: idx = 6'd4;
                {7'h00, 3'd1}: idx = 6'd5;
                {7'h00, 3'd5}: idx = 6'd6;
                {7'h20, 3'd5}: idx = 6'd7;
                {7'h00, 3'd2}: idx = 6'd8;
                {7'h00, 3'd3}: idx = 6'd9;
`ifdef RV32M_EN
                default: idx = (f7 == 7'h01) ? 6'd38 + {3'd0, f3} : ILL;
`else
                default: idx = ILL;
`endif
            endcase
            OP_I: case (f3)
                3'd0: idx = 6'd10;
                3'd4: idx = 6'd11;
                3'd6: idx = 6'd12;
                3'd7: idx = 6'd13;
                3'd1: idx = (f7 == 7'h00) ? 6'd14 : ILL;
                3'd5: idx = (f7 == 7'h00) ? 6'd15 : (f7 == 7'h20) ? 6'd16 : ILL;
                3'd2: idx = 6'd17;
                default: idx = 6'd18;
            endcase
            OP_L: case (f3)
                3'd0: idx = 6'd19;
                3'd1: idx = 6'd20;
                3'd2: idx = 6'd21;
                3'd4: idx = 6'd22;
                3'd5: idx = 6'd23;
                default: idx = ILL;
            endcase
            OP_S: idx = (f3 < 3'd3) ? 6'd24 + {3'd0, f3} : ILL;
            OP_B: case (f3)
                3'd0: idx = 6'd27;
                3'd1: idx = 6'd28;
                3'd4: idx = 6'd29;
                3'd5: idx = 6'd30;
                3'd6: idx = 6'd31;
                3'd7: idx = 6'd32;
                default: idx = ILL;
            endcase
            OP_JAL:   idx = 6'd33;
            OP_JALR:  idx = (f3 == 3'd0) ? 6'd34 : ILL;
            OP_LUI:   idx = 6'd35;
            OP_AUIPC: idx = 6'd36;
            default:  idx = ILL;
        endcase
    end

    assign ok = idx != ILL;
    assign tr = ok && opc == OP_R;
    assign ti = ok && (opc == OP_I || opc == OP_L || opc == OP_JALR);
    assign ts = ok && opc == OP_S;
    assign tb = ok && opc == OP_B;
    assign tj = ok && opc == OP_JAL;
    assign tu = ok && (opc == OP_LUI || opc == OP_AUIPC);

    assign bus = v ? (BUS_W'(1) << idx) : '0;

    assign dif.out_pc      = hpc;
    assign dif.rs1         = x[19:15];
    assign dif.rs2         = x[24:20];
    assign dif.rd          = x[11:7];
    assign dif.func3       = f3;
    assign dif.func7       = f7;
    assign dif.imm         = ti ? {{20{x[31]}}, x[31:20]} :
                             ts ? {{20{x[31]}}, x[31:25], x[11:7]} :
                             tb ? {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0} :
                             tu ? {x[31:12], 12'b0} :
                             tj ? {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0} : 32'd0;
    assign dif.rs1_valid   = tr || ti || ts || tb;
    assign dif.func3_valid = tr || ti || ts || tb;
    assign dif.rs2_valid   = tr || ts || tb;
    assign dif.rd_valid    = tr || ti || tu || tj;
    assign dif.func7_valid = tr;
    assign dif.imm_valid   = ti || ts || tb || tu || tj;
    assign dif.instr_bus   = bus;
    assign dif.illegal     = bus[37];
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized scoreboard bench for decode_stage (RV32M_EN follows the build).
module tb_decode_stage;
`ifdef RV32M_EN
    localparam int BUS_W = 46;
    localparam int NT    = 45;
`else
    localparam int BUS_W = 38;
    localparam int NT    = 37;
`endif
    localparam int BUF_DEPTH = 2;
    localparam int OW        = 96 + BUS_W;
    localparam logic [31:0] ADDI = 32'h00500093, SUB = 32'h402081B3, JAL = 32'hFFDFF0EF,
                            MUL = 32'h027302B3;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    // Opcode map as {bus bit, opcode, func3 (FF = any), func7 (FF = any)}
    logic [31:0] tbl [0:44] = '{
        32'h00_33_00_00, 32'h01_33_00_20, 32'h02_33_04_00, 32'h03_33_06_00, 32'h04_33_07_00,
        32'h05_33_01_00, 32'h06_33_05_00, 32'h07_33_05_20, 32'h08_33_02_00, 32'h09_33_03_00,
        32'h0A_13_00_FF, 32'h0B_13_04_FF, 32'h0C_13_06_FF, 32'h0D_13_07_FF, 32'h0E_13_01_00,
        32'h0F_13_05_00, 32'h10_13_05_20, 32'h11_13_02_FF, 32'h12_13_03_FF, 32'h13_03_00_FF,
        32'h14_03_01_FF, 32'h15_03_02_FF, 32'h16_03_04_FF, 32'h17_03_05_FF, 32'h18_23_00_FF,
        32'h19_23_01_FF, 32'h1A_23_02_FF, 32'h1B_63_00_FF, 32'h1C_63_01_FF, 32'h1D_63_04_FF,
        32'h1E_63_05_FF, 32'h1F_63_06_FF, 32'h20_63_07_FF, 32'h21_6F_FF_FF, 32'h22_67_00_FF,
        32'h23_37_FF_FF, 32'h24_17_FF_FF, 32'h26_33_00_01, 32'h27_33_01_01, 32'h28_33_02_01,
        32'h29_33_03_01, 32'h2A_33_04_01, 32'h2B_33_05_01, 32'h2C_33_06_01, 32'h2D_33_07_01
    };

    decode_if #(.PC_W(32)) dif ();
    decode_stage #(.PC_W(32), .BUF_DEPTH(BUF_DEPTH)) dut (.clk(clk), .rst(rst), .dif(dif));

    always #5 clk = ~clk;

    function automatic int find(input logic [31:0] x);
        logic [31:0] e;
        for (int k = 0; k < NT; k++) begin
            e = tbl[k];
            if (x[6:0] == e[22:16] && (e[15:8] == 8'hFF || x[14:12] == e[10:8]) &&
                (e[7:0] == 8'hFF || x[31:25] == e[6:0])) return int'(e[31:24]);
        end
        return -1;
    endfunction

    function automatic byte typ(input logic [6:0] o);
        case (o)
            7'h33: return "R";
            7'h13, 7'h03, 7'h67: return "I";
            7'h23: return "S";
            7'h63: return "B";
            7'h6F: return "J";
            default: return "U";
        endcase
    endfunction

    function automatic logic [OW-1:0] expv(input logic [31:0] p, input logic [31:0] x);
        int               b;
        byte              t;
        logic [31:0]      im;
        logic [BUS_W-1:0] bv;
        logic             v1, v2, vd, v7, vi;
        b = find(x);
        t = (b < 0) ? "X" : typ(x[6:0]);
        case (t)
            "I": im = 32'($signed(x[31:20]));
            "S": im = 32'($signed({x[31:25], x[11:7]}));
            "B": im = 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
            "U": im = {x[31:12], 12'h000};
            "J": im = 32'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
            default: im = 32'd0;
        endcase
        v1 = (t == "R" || t == "I" || t == "S" || t == "B");
        v2 = (t == "R" || t == "S" || t == "B");
        vd = (t == "R" || t == "I" || t == "U" || t == "J");
        v7 = (t == "R");
        vi = (t == "I" || t == "S" || t == "B" || t == "U" || t == "J");
        bv = '0;
        bv[(b < 0) ? 37 : b] = 1'b1;
        return {p, x[11:7], x[19:15], x[24:20], x[14:12], x[31:25], im, v1, v2, vd, v1, v7, vi, bv, b < 0};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {dif.out_pc, dif.rd, dif.rs1, dif.rs2, dif.func3, dif.func7, dif.imm,
                dif.rs1_valid, dif.rs2_valid, dif.rd_valid, dif.func3_valid, dif.func7_valid,
                dif.imm_valid, dif.instr_bus, dif.illegal};
    endfunction

    function automatic logic [31:0] gen(input int k);
        logic [31:0] e;
        logic [31:0] x;
        e = tbl[k];
        x = $urandom;
        x[6:0] = e[22:16];
        if (e[15:8] != 8'hFF) x[14:12] = e[10:8];
        if (e[7:0] != 8'hFF) x[31:25] = e[6:0];
        return x;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear;
        dif.flush = 1'b1;
        dif.in_valid = 1'b0;
        tick;
        dif.flush = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        dif.flush = 1'b0;
        dif.in_valid = 1'b0;
        dif.instr = '0;
        dif.pc = '0;
        dif.out_ready = 1'b0;
        tick;
        tick;
        tests++; if (dif.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready_in_rst got %b want 0", dif.in_ready); end
        rst = 1'b0;
        #1;
        tests++; if (dif.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", dif.out_valid); end
        tests++; if (dif.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", dif.in_ready); end
        tests++; if (obs() !== '0) begin fails++; $display("FAIL reset_payload got %h want 0", obs()); end
        tick;
        tests++; if (dif.out_valid !== 1'b0 || obs() !== '0) begin fails++; $display("FAIL reset_idle got v=%b %h want v=0 0", dif.out_valid, obs()); end
    endtask

    task automatic test_addi;
        clear;
        dif.out_ready = 1'b1;
        dif.in_valid = 1'b1;
        dif.instr = ADDI;
        dif.pc = 32'h100;
        tick;
        dif.in_valid = 1'b0;
        tests++; if (dif.out_valid !== 1'b1) begin fails++; $display("FAIL addi_out_valid got %b want 1", dif.out_valid); end
        tests++; if ({dif.rd, dif.rs1, dif.imm, dif.instr_bus[10], dif.rs2_valid} !== {5'd1, 5'd0, 32'd5, 1'b1, 1'b0})
            begin fails++; $display("FAIL addi_fields got rd=%0d rs1=%0d imm=%h b10=%b rs2v=%b want 1 0 5 1 0", dif.rd, dif.rs1, dif.imm, dif.instr_bus[10], dif.rs2_valid); end
        tests++; if (obs() !== expv(32'h100, ADDI)) begin fails++; $display("FAIL addi_all got %h want %h", obs(), expv(32'h100, ADDI)); end
        tick;
        tests++; if (dif.out_valid !== 1'b0) begin fails++; $display("FAIL addi_popped got %b want 0", dif.out_valid); end
    endtask

    task automatic test_backpressure;
        clear;
        dif.out_ready = 1'b0;
        dif.in_valid = 1'b1;
        dif.instr = SUB;
        dif.pc = 32'h10;
        #1;
        tests++; if (dif.in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready0 got %b want 1", dif.in_ready); end
        tick;
        dif.instr = JAL;
        dif.pc = 32'h14;
        tests++; if (dif.in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got %b want 1", dif.in_ready); end
        tick;
        dif.instr = ADDI;
        tests++; if (dif.in_ready !== 1'b0) begin fails++; $display("FAIL bp_full got %b want 0", dif.in_ready); end
        tick;
        dif.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tests++; if (dif.out_valid !== 1'b1 || dif.instr_bus[1] !== 1'b1 || obs() !== expv(32'h10, SUB))
                begin fails++; $display("FAIL bp_hold%0d got %h want %h", c, obs(), expv(32'h10, SUB)); end
            tick;
        end
        dif.out_ready = 1'b1;
        tick;
        tests++; if (dif.imm !== 32'hFFFFFFFC || dif.instr_bus[33] !== 1'b1 || obs() !== expv(32'h14, JAL))
            begin fails++; $display("FAIL bp_jal got %h want %h", obs(), expv(32'h14, JAL)); end
        tick;
        tests++; if (dif.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got %b want 0", dif.out_valid); end
    endtask

    task automatic test_mul;
        clear;
        dif.out_ready = 1'b1;
        dif.in_valid = 1'b1;
        dif.instr = MUL;
        dif.pc = 32'h200;
        tick;
        dif.in_valid = 1'b0;
`ifdef RV32M_EN
        tests++; if (dif.instr_bus[38] !== 1'b1 || dif.rd !== 5'd5 || dif.illegal !== 1'b0)
            begin fails++; $display("FAIL mul_m got b38=%b rd=%0d ill=%b want 1 5 0", dif.instr_bus[38], dif.rd, dif.illegal); end
`else
        tests++; if (dif.instr_bus[37] !== 1'b1 || dif.illegal !== 1'b1 ||
                     {dif.rs1_valid, dif.rs2_valid, dif.rd_valid, dif.func3_valid, dif.func7_valid, dif.imm_valid} !== 6'd0)
            begin fails++; $display("FAIL mul_illegal got b37=%b ill=%b want 1 1, valids 0", dif.instr_bus[37], dif.illegal); end
`endif
        tests++; if (obs() !== expv(32'h200, MUL)) begin fails++; $display("FAIL mul_all got %h want %h", obs(), expv(32'h200, MUL)); end
        tick;
    endtask

    task automatic test_flush;
        clear;
        dif.out_ready = 1'b0;
        dif.in_valid = 1'b1;
        dif.instr = ADDI;
        dif.pc = 32'h1;
        tick;
        dif.instr = SUB;
        dif.pc = 32'h2;
        tick;
        dif.flush = 1'b1;
        dif.instr = 32'h00A00113;
        dif.pc = 32'h3;
        tick;
        dif.flush = 1'b0;
        dif.in_valid = 1'b0;
        tests++; if (dif.out_valid !== 1'b0 || dif.in_ready !== 1'b1)
            begin fails++; $display("FAIL flush_full got v=%b r=%b want 0 1", dif.out_valid, dif.in_ready); end
        dif.in_valid = 1'b1;
        dif.instr = SUB;
        dif.pc = 32'h4;
        tick;
        dif.flush = 1'b1;
        dif.out_ready = 1'b1;
        dif.instr = JAL;
        dif.pc = 32'h5;
        tick;
        dif.flush = 1'b0;
        dif.in_valid = 1'b0;
        tests++; if (dif.out_valid !== 1'b0) begin fails++; $display("FAIL flush_push_dropped got %b want 0", dif.out_valid); end
        dif.in_valid = 1'b1;
        dif.instr = 32'h00300193;
        dif.pc = 32'h6;
        tick;
        dif.in_valid = 1'b0;
        tests++; if (obs() !== expv(32'h6, 32'h00300193)) begin fails++; $display("FAIL flush_after got %h want %h", obs(), expv(32'h6, 32'h00300193)); end
        tick;
        tests++; if (dif.out_valid !== 1'b0) begin fails++; $display("FAIL flush_drain got %b want 0", dif.out_valid); end
    endtask

    task automatic test_stream;
        logic [63:0] q[$];
        clear;
        dif.out_ready = 1'b1;
        for (int c = 0; c < 102; c++) begin
            dif.in_valid = (c < 100);
            dif.instr = gen($urandom_range(0, NT - 1));
            dif.pc = 32'(c * 4);
            #1;
            tests++; if (dif.out_valid !== (c >= 1 && c <= 100) || (c < 100 && dif.in_ready !== 1'b1))
                begin fails++; $display("FAIL stream_flow c=%0d got v=%b r=%b", c, dif.out_valid, dif.in_ready); end
            if (dif.out_valid) begin
                tests++; if (q.size() == 0 || obs() !== expv(q[0][63:32], q[0][31:0]) || $countones(dif.instr_bus) != 1)
                    begin fails++; $display("FAIL stream_data c=%0d got %h", c, obs()); end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (dif.in_valid && dif.in_ready) q.push_back({dif.pc, dif.instr});
            tick;
        end
        tests++; if (q.size() != 0) begin fails++; $display("FAIL stream_leftover got %0d want 0", q.size()); end
    endtask

    task automatic test_random;
        logic [63:0] q[$];
        clear;
        for (int c = 0; c < 300; c++) begin
            dif.in_valid = 1'($urandom_range(0, 1));
            dif.out_ready = 1'($urandom_range(0, 1));
            dif.instr = ($urandom_range(0, 3) == 0) ? 32'($urandom) : gen($urandom_range(0, NT - 1));
            dif.pc = $urandom;
            #1;
            tests++; if (dif.out_valid !== (q.size() != 0) || dif.in_ready !== (q.size() < BUF_DEPTH))
                begin fails++; $display("FAIL rand_flags c=%0d got v=%b r=%b want occupancy %0d", c, dif.out_valid, dif.in_ready, q.size()); end
            if (dif.out_valid && dif.out_ready) begin
                tests++; if (q.size() == 0 || obs() !== expv(q[0][63:32], q[0][31:0]))
                    begin fails++; $display("FAIL rand_data c=%0d got %h", c, obs()); end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (dif.in_valid && dif.in_ready) q.push_back({dif.pc, dif.instr});
            tick;
        end
        dif.in_valid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_addi;
        test_backpressure;
        test_mul;
        test_flush;
        test_stream;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
